// File: rtl/crc32_pkg.sv
// CRC-32 constants and the byte-step helper shared by the
// streaming CRC datapath.
package crc32_pkg;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'h0;
    localparam int          BEAT_BYTES = 32;

    // Eight MSB-first bit steps of the non-reflected CRC
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] i32_C,
        input logic [7:0]  i8_Byte
    );
        logic [31:0] r32_C;
        r32_C = i32_C;
        for (int k = 7; k >= 0; k--) begin
            if (r32_C[31] ^ i8_Byte[k])
                r32_C = {r32_C[30:0], 1'b0} ^ CRC_POLY;
            else
                r32_C = {r32_C[30:0], 1'b0};
        end
        return r32_C;
    endfunction

endpackage

// File: rtl/crc32_256_if.sv
// Beat bus between the packet datapath and the CRC block.
interface crc32_256_if;
    import crc32_pkg::*;

    logic [8*BEAT_BYTES-1:0] iv_Input;
    logic                    i_Dv;
    logic                    i_SoP;
    logic                    i_EoP;
    logic [4:0]              i5_SoPEmpty;
    logic [4:0]              i5_EoPEmpty;
    logic                    o_CrcV;
    logic [31:0]             o32_Crc;

    modport master (
        output iv_Input, i_Dv, i_SoP, i_EoP,
        output i5_SoPEmpty, i5_EoPEmpty,
        input  o_CrcV, o32_Crc
    );

    modport slave (
        input  iv_Input, i_Dv, i_SoP, i_EoP,
        input  i5_SoPEmpty, i5_EoPEmpty,
        output o_CrcV, o32_Crc
    );

endinterface

// File: rtl/crc32_256_update.sv
// Combinational CRC advance over the contiguous valid byte
// window [i5_First, i5_Last] of one 32-byte beat.
module crc32_256_update
    import crc32_pkg::*;
(
    input  logic [31:0]             i32_State,
    input  logic [8*BEAT_BYTES-1:0] iv_Data,
    input  logic [4:0]              i5_First,
    input  logic [4:0]              i5_Last,
    output logic [31:0]             o32_Next
);

    logic [31:0] w32_Acc;
    logic [7:0]  w8_Byte;

    // Bytes outside the window pass the state through untouched;
    // an empty window (first > last) leaves the state as is.
    always_comb begin
        w32_Acc = i32_State;
        w8_Byte = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            w8_Byte = iv_Data[8*(BEAT_BYTES-1-i) +: 8];
            if ((5'(i) >= i5_First) && (5'(i) <= i5_Last))
                w32_Acc = crc32_byte(w32_Acc, w8_Byte);
        end
    end

    assign o32_Next = w32_Acc;

endmodule

// File: rtl/crc32_256.sv
// Streaming CRC-32 over 256-bit beats with byte-trimmed
// start/end; one-cycle result pulse after each EoP beat.
module crc32_256
    import crc32_pkg::*;
(
    input  logic         i_Clk,
    input  logic         i_Clr,
    crc32_256_if.slave   io_Bus
);

    logic [31:0] r32_CrcQ;
    logic [31:0] r32_Crc;
    logic        r_CrcV;

    logic [31:0] w32_Base;
    logic [31:0] w32_Next;
    logic [4:0]  w5_First;
    logic [4:0]  w5_Last;

    // SoP always restarts from the initial value
    assign w32_Base = io_Bus.i_SoP ? CRC_INIT : r32_CrcQ;
    assign w5_First = io_Bus.i_SoP ? io_Bus.i5_SoPEmpty : 5'd0;
    assign w5_Last  = io_Bus.i_EoP ? 5'd31 - io_Bus.i5_EoPEmpty
                                   : 5'd31;

    crc32_256_update u_update (
        .i32_State (w32_Base),
        .iv_Data   (io_Bus.iv_Input),
        .i5_First  (w5_First),
        .i5_Last   (w5_Last),
        .o32_Next  (w32_Next)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Clr) begin
            r32_CrcQ <= CRC_INIT;
            r32_Crc  <= '0;
            r_CrcV   <= 1'b0;
        end else begin
            r_CrcV <= 1'b0;
            if (io_Bus.i_Dv) begin
                r32_CrcQ <= w32_Next;
                if (io_Bus.i_EoP) begin
                    r32_Crc <= w32_Next;
                    r_CrcV  <= 1'b1;
                end
            end
        end
    end

    assign io_Bus.o_CrcV  = r_CrcV;
    assign io_Bus.o32_Crc = r32_Crc;

endmodule

// File: tb/tb_crc32_256.sv
// Bench for crc32_256: directed vectors plus random packets
// against a bit-serial model of the packet byte stream.
module tb_crc32_256;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk;
    logic clr;

    crc32_256_if bus ();

    crc32_256 dut (
        .i_Clk  (clk),
        .i_Clr  (clr),
        .io_Bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_fail;
    logic [7:0]  pkt[$];
    logic [31:0] last_crc;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden();
        logic [31:0] c;
        logic        fb;
        c = 32'h0;
        foreach (pkt[j]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[31] ^ pkt[j][k];
                c = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
            end
        end
        return c;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++)
            v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic beat(input bit dv, input bit sop,
                        input bit eop,
                        input logic [4:0] se,
                        input logic [4:0] ee,
                        input logic [255:0] d);
        int lo;
        int hi;
        bus.i_Dv        = dv;
        bus.i_SoP       = sop;
        bus.i_EoP       = eop;
        bus.i5_SoPEmpty = se;
        bus.i5_EoPEmpty = ee;
        bus.iv_Input    = d;
        @(posedge clk);
        #1;
        if (dv) begin
            if (sop) pkt.delete();
            lo = sop ? int'(se) : 0;
            hi = eop ? 31 - int'(ee) : 31;
            for (int i = lo; i <= hi; i++)
                pkt.push_back(d[255-8*i -: 8]);
        end
        if (dv && eop) begin
            last_crc = golden();
            check("crcv_eop", 32'(bus.o_CrcV), 32'd1);
        end else begin
            check("crcv_idle", 32'(bus.o_CrcV), 32'd0);
        end
        check("crc", bus.o32_Crc, last_crc);
    endtask

    task automatic gap();
        beat(1'b0, 1'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), rnd256());
    endtask

    task automatic do_clr();
        clr             = 1'b1;
        bus.i_Dv        = 1'b1;
        bus.i_SoP       = 1'b1;
        bus.i_EoP       = 1'b1;
        bus.i5_SoPEmpty = 5'd0;
        bus.i5_EoPEmpty = 5'd0;
        bus.iv_Input    = rnd256();
        @(posedge clk);
        #1;
        clr = 1'b0;
        pkt.delete();
        last_crc = 32'h0;
        check("clr_crcv", 32'(bus.o_CrcV), 32'd0);
        check("clr_crc", bus.o32_Crc, 32'h0);
    endtask

    initial begin
        logic [255:0] d;
        logic [7:0]   data[];
        int           len;
        int           off;
        int           tot;
        int           nb;
        int           ee;
        int           g;
        n_chk    = 0;
        n_fail   = 0;
        last_crc = 32'h0;
        clr      = 1'b0;
        do_clr();
        do_clr();

        d = '0;
        for (int i = 0; i < 9; i++)
            d[255-8*i -: 8] = 8'h31 + 8'(i);
        beat(1, 1, 1, 5'd0, 5'd23, d);
        check("std9", bus.o32_Crc, 32'h89A1897F);
        gap();

        for (int i = 0; i < 32; i++)
            d[255-8*i -: 8] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 9; i++)
            d[255-8*(i+5) -: 8] = 8'h31 + 8'(i);
        beat(1, 1, 1, 5'd5, 5'd18, d);
        check("std9_off", bus.o32_Crc, 32'h89A1897F);

        for (int i = 0; i < 32; i++)
            d[255-8*i -: 8] = 8'(i);
        beat(1, 1, 0, 5'd0, 5'd0, d);
        for (int i = 0; i < 32; i++)
            d[255-8*i -: 8] = 8'(32 + i);
        beat(1, 0, 1, 5'd0, 5'd0, d);
        gap();
        gap();

        beat(1, 1, 0, 5'd7, 5'd0, 256'h0);
        beat(1, 0, 0, 5'd3, 5'd9, 256'h0);
        beat(1, 0, 1, 5'd0, 5'd4, 256'h0);
        check("zero_pkt", bus.o32_Crc, 32'h0);
        beat(1, 1, 1, 5'd20, 5'd12, rnd256());
        check("empty_beat", bus.o32_Crc, 32'h0);

        beat(1, 0, 1, 5'd0, 5'd30, rnd256());
        beat(1, 1, 0, 5'd3, 5'd0, rnd256());
        beat(1, 0, 0, 5'd0, 5'd0, rnd256());
        do_clr();
        gap();
        beat(1, 0, 1, 5'd0, 5'd10, rnd256());
        beat(1, 1, 0, 5'd2, 5'd0, rnd256());
        beat(1, 0, 1, 5'd0, 5'd17, rnd256());

        for (int p = 0; p < 200; p++) begin
            len  = $urandom_range(64, 400);
            off  = $urandom_range(0, 31);
            data = new[len];
            foreach (data[j]) data[j] = 8'($urandom);
            tot = off + len;
            nb  = (tot + 31) / 32;
            ee  = nb * 32 - tot;
            for (int b = 0; b < nb; b++) begin
                d = rnd256();
                for (int i = 0; i < 32; i++) begin
                    g = b * 32 + i;
                    if (g >= off && g < tot)
                        d[255-8*i -: 8] = data[g-off];
                end
                if (b > 0 && ($urandom % 4) == 0) gap();
                beat(1, b == 0, b == nb - 1,
                     (b == 0) ? 5'(off) : 5'($urandom),
                     (b == nb - 1) ? 5'(ee) : 5'($urandom),
                     d);
            end
            if (($urandom % 2) == 0) gap();
        end

        gap();
        $display("TB_RESULT checks=%0d failures=%0d",
                 n_chk, n_fail);
        $finish;
    end

endmodule
